dp_stream_collector: RTL and testbench
======================================

// Module: dp_stream_collector
// PURPOSE
// - Output stage directly downstream of the data_path pipeline: captures stream_out phits, re-times them to AXI-Stream.
// - data_path carries no valid/ready, so this block tracks issued phits through a PIPE_LAT-deep valid shift register.
// - It samples data_path output when each valid emerges and buffers it in a FIFO.
// - Credit-based issue_ready guarantees buffer space for every in-flight phit, so downstream backpressure never loses data.
// PARAMETERS
// - PHIT_W    default phit_size  width of one phit (data_path stream_out width)
// - PIPE_LAT  default 4          cycles from issue at data_path inputs to result on stream_out; 1..32
// - DEPTH     default 16         total buffer slots incl. output register; power of 2, >= PIPE_LAT+2 for full throughput
// - CNT_W     default $clog2(DEPTH+1)  width of credit counter (derived, not overridden)
// PORTS
// - clk            in   1        single clock, all logic rising-edge
// - rst            in   1        synchronous, active-high reset
// - issue_valid    in   1        a phit is presented to data_path inputs this cycle
// - issue_last     in   1        that phit ends a message; travels with its valid
// - issue_ready    out  1        credit available; issue accepted only when valid & ready
// - dp_data        in   PHIT_W   data_path stream_out
// - m_axis_tdata   out  PHIT_W   result phit
// - m_axis_tlast   out  1        end-of-message marker
// - m_axis_tvalid  out  1        result valid
// - m_axis_tready  in   1        downstream accepts
// - used_count     out  CNT_W    credits consumed (in flight + buffered)
// - proto_err      out  1        sticky: issue_valid seen while issue_ready=0
// BEHAVIOUR
// - Reset (rst=1 at edge): clears valid/last shift register, FIFO pointers, output register, credit counter and proto_err.
//   - Next cycle outputs: tvalid=0, tdata=0, tlast=0, used_count=0, proto_err=0, issue_ready=1.
//   - issue_ready is forced 0 while rst is high.
//   - A reset mid-operation discards all in-flight and buffered phits; none emerge afterward.
// - Accept: acc = issue_valid & issue_ready; shift reg stage0 <= {acc, issue_last}; shifts one stage per cycle.
// - Capture: when stage PIPE_LAT-1 is valid, dp_data and its last bit are pushed into the FIFO that same edge.
//   - This aligns with the phit issued PIPE_LAT cycles earlier.
// - Output register: loads from the FIFO head when empty or when (tvalid & tready).
//   - tdata/tlast are held stable while tvalid & !tready.
// - Latency: issue at edge N -> push at N+PIPE_LAT -> tvalid high from cycle N+PIPE_LAT+1 (empty-path bypass into output reg).
// - Credits: used_count += acc; -= (tvalid & tready); both in the same cycle -> unchanged.
//   - issue_ready = !rst & (used_count < DEPTH), combinational from the registered count.
// - Full: used_count==DEPTH -> issue_ready=0.
//   - A pop that cycle makes ready 1 in the following cycle, not combinationally.
// - FIFO never overflows by construction; an internal assertion fires if push occurs when full.
// - Empty: tvalid=0; tdata holds its last value (don't-care).
// - Protocol error: issue_valid & !issue_ready sets proto_err (sticky until rst).
//   - The phit is not tracked, the counter is unchanged, and nothing is pushed for it.
// - Pointers wrap modulo DEPTH; simultaneous push and pop at any occupancy is legal, order strictly FIFO.
// - Throughput: with tready=1 and DEPTH>=PIPE_LAT+2, issue_ready stays 1 and one phit per cycle is sustained.
// STRUCTURE
// - Shared header my_interface.vh: phit_size (existing) plus new constant DP_PIPE_LAT, the pipeline latency of data_path.
// - Sub-module sync_fifo (PHIT_W+1 wide, DEPTH-1 entries, registered pointers, sync reset).
// - Top holds the shift register, credit counter, output register and proto_err.
// TESTING
// - Reset: hold rst 3 cycles -> tvalid=0, tdata=0, tlast=0, used_count=0, proto_err=0; issue_ready=0 during rst, 1 after.
// - Single phit (PIPE_LAT=4): issue at cycle 10, last=1, dp_data=64'hA5A5_0001 at cycle 14
//   -> tvalid=1 at cycle 15, that data, tlast=1; used_count 1 -> 0 on handshake.
// - Backpressure (DEPTH=16): tready=0, issue_valid held 20 cycles -> exactly 16 accepted, issue_ready=0 after 16th, proto_err=0.
//   - Then tready=1 -> 16 phits in issue order; issue_ready=1 the cycle after first pop.
// - Streaming: tready=1, 100 back-to-back issues with incrementing data
//   -> issue_ready never drops, tvalid continuous for 100 cycles from first output, data 0..99 in order.
// - Protocol error: fill to 16 with tready=0, drive issue_valid 1 cycle
//   -> proto_err=1 and stays 1, used_count=16, only 16 phits emerge.
// - Mid-operation reset: 3 in flight + 5 buffered, pulse rst 1 cycle
//   -> next cycle tvalid=0, used_count=0; no stale phit appears in the following 2*PIPE_LAT cycles.

Source files
------------

// File: rtl/dp_stream_collector_pkg.sv
// -----------------------------------------------------------------------------
// dp_stream_collector_pkg
// Shared constants for the data_path output stage.
//   PHIT_SIZE    width of one data_path stream_out phit
//   DP_PIPE_LAT  cycles from issue at data_path inputs to result on stream_out
//   DEF_DEPTH    default number of buffer slots in the collector
//   out_src_e    where the output register reloads from in a given cycle
// -----------------------------------------------------------------------------
package dp_stream_collector_pkg;

   localparam int PHIT_SIZE   = 64;
   localparam int DP_PIPE_LAT = 4;
   localparam int DEF_DEPTH   = 16;

   typedef enum logic [1:0] {
      SRC_NONE   = 2'd0,  // nothing available, output register goes empty/holds
      SRC_FIFO   = 2'd1,  // pop the FIFO head
      SRC_BYPASS = 2'd2   // FIFO empty: take the phit being captured this edge
   } out_src_e;

endpackage

// File: rtl/dp_stream_collector_sync_fifo.sv
// -----------------------------------------------------------------------------
// dp_stream_collector_sync_fifo
// Single-clock FIFO with registered pointers and synchronous active-high reset.
// ENTRIES need not be a power of two; pointers wrap explicitly at ENTRIES.
// Ports:
//   clk, rst   clock / synchronous reset (clears pointers and count)
//   push_i     write data_i this edge (must not be full unless also popping)
//   data_i     write data
//   pop_i      advance read pointer this edge (must not be empty)
//   data_o     current head entry (valid when !empty_o)
//   empty_o    no entries stored
//   full_o     ENTRIES entries stored
// -----------------------------------------------------------------------------
module dp_stream_collector_sync_fifo #(
   parameter int WIDTH   = 65,
   parameter int ENTRIES = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int CNT_W = $clog2(ENTRIES + 1);

   logic [WIDTH-1:0] mem_q [ENTRIES];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign data_o  = mem_q[rd_ptr_q];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(ENTRIES));

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the block leaves it unassigned, which would infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers/count define which
   // entries are meaningful, and leaving the array unreset lets it map to RAM.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/dp_stream_collector.sv
// -----------------------------------------------------------------------------
// dp_stream_collector
// Output stage behind the data_path pipeline. data_path has no handshake, so
// each accepted issue is tracked through a PIPE_LAT-deep valid/last shift
// register; when a valid reaches the end, dp_data is captured into a FIFO and
// re-timed onto AXI-Stream. Credits (used_count) cover every phit in flight or
// buffered, so downstream backpressure can never drop a phit.
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   issue_valid     phit presented to data_path this cycle
//   issue_last      that phit ends a message
//   issue_ready     credit available (forced 0 during reset)
//   dp_data         data_path stream_out
//   m_axis_tdata    result phit
//   m_axis_tlast    end-of-message marker
//   m_axis_tvalid   result valid
//   m_axis_tready   downstream accepts
//   used_count      credits consumed (in flight + buffered + output register)
//   proto_err       sticky: issue_valid seen while issue_ready was low
// -----------------------------------------------------------------------------
module dp_stream_collector
   import dp_stream_collector_pkg::*;
#(
   parameter  int PHIT_W   = PHIT_SIZE,
   parameter  int PIPE_LAT = DP_PIPE_LAT,
   parameter  int DEPTH    = DEF_DEPTH,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              issue_last,
   output logic              issue_ready,
   input  logic [PHIT_W-1:0] dp_data,
   output logic [PHIT_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [CNT_W-1:0]  used_count,
   output logic              proto_err
);

   // Issue tracking shift register: bit 0 is the newest issue.
   logic [PIPE_LAT-1:0] vld_q, vld_d;
   logic [PIPE_LAT-1:0] last_q, last_d;

   logic [PHIT_W-1:0] tdata_q, tdata_d;
   logic              tlast_q, tlast_d;
   logic              tvalid_q, tvalid_d;
   logic [CNT_W-1:0]  used_q, used_d;
   logic              proto_err_q, proto_err_d;

   logic              acc;
   logic              cap;
   logic              cap_last;
   logic              load_en;
   logic              handshake;
   out_src_e          src;

   logic              fifo_push;
   logic              fifo_pop;
   logic [PHIT_W:0]   fifo_head;
   logic              fifo_empty;
   logic              fifo_full;

   // Ready depends only on the registered count, so a pop never opens a credit
   // combinationally; the freed slot shows up one cycle later.
   assign issue_ready = !rst && (used_q < CNT_W'(DEPTH));
   assign acc         = issue_valid && issue_ready;
   assign cap         = vld_q[PIPE_LAT-1];
   assign cap_last    = last_q[PIPE_LAT-1];
   assign handshake   = tvalid_q && m_axis_tready;
   assign load_en     = !tvalid_q || m_axis_tready;

   always_comb begin
      vld_d     = '0;
      last_d    = '0;
      vld_d[0]  = acc;
      last_d[0] = acc && issue_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
         vld_d[i]  = vld_q[i-1];
         last_d[i] = last_q[i-1];
      end
   end

   // Output register source: the FIFO head always has priority so order is
   // preserved; the captured phit bypasses the FIFO only when it is empty.
   always_comb begin
      src = SRC_NONE;
      if (load_en) begin
         if (!fifo_empty) src = SRC_FIFO;
         else if (cap)    src = SRC_BYPASS;
      end

      fifo_pop  = (src == SRC_FIFO);
      fifo_push = cap && (src != SRC_BYPASS);

      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      if (load_en) tvalid_d = (src != SRC_NONE);
      case (src)
         SRC_FIFO:   {tlast_d, tdata_d} = fifo_head;
         SRC_BYPASS: {tlast_d, tdata_d} = {cap_last, dp_data};
         default:    ;
      endcase

      used_d      = used_q + CNT_W'(acc) - CNT_W'(handshake);
      proto_err_d = proto_err_q || (issue_valid && !issue_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q       <= '0;
         last_q      <= '0;
         tdata_q     <= '0;
         tlast_q     <= 1'b0;
         tvalid_q    <= 1'b0;
         used_q      <= '0;
         proto_err_q <= 1'b0;
      end else begin
         vld_q       <= vld_d;
         last_q      <= last_d;
         tdata_q     <= tdata_d;
         tlast_q     <= tlast_d;
         tvalid_q    <= tvalid_d;
         used_q      <= used_d;
         proto_err_q <= proto_err_d;
      end
   end

   // The output register is one of the DEPTH slots, so the FIFO holds DEPTH-1.
   dp_stream_collector_sync_fifo #(
      .WIDTH   (PHIT_W + 1),
      .ENTRIES (DEPTH - 1)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .data_i  ({cap_last, dp_data}),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tvalid = tvalid_q;
   assign used_count    = used_q;
   assign proto_err     = proto_err_q;

   // A full FIFO plus the output register already accounts for every credit.
   a_credit_bound: assert property (@(posedge clk) disable iff (rst) used_q <= CNT_W'(DEPTH));
   a_full_credit:  assert property (@(posedge clk) disable iff (rst) fifo_full |-> (used_q == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_dp_stream_collector.sv
// -----------------------------------------------------------------------------
// tb_dp_stream_collector
// Stimulus bench for dp_stream_collector. The bench plays the part of data_path:
// an accepted issue schedules its payload onto dp_data exactly PIPE_LAT cycles
// later; every other cycle dp_data carries random garbage. Expected output is a
// queue of accepted phits, each tagged with the first cycle it may appear.
// -----------------------------------------------------------------------------
module tb_dp_stream_collector;

   localparam int PHIT_W   = 64;
   localparam int PIPE_LAT = 4;
   localparam int DEPTH    = 16;
   localparam int CNT_W    = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              issue_valid = 1'b0;
   logic              issue_last = 1'b0;
   logic              issue_ready;
   logic [PHIT_W-1:0] dp_data = '0;
   logic [PHIT_W-1:0] m_axis_tdata;
   logic              m_axis_tlast;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b0;
   logic [CNT_W-1:0]  used_count;
   logic              proto_err;

   always #5 clk = ~clk;

   dp_stream_collector #(
      .PHIT_W   (PHIT_W),
      .PIPE_LAT (PIPE_LAT),
      .DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .issue_valid   (issue_valid),
      .issue_last    (issue_last),
      .issue_ready   (issue_ready),
      .dp_data       (dp_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .used_count    (used_count),
      .proto_err     (proto_err)
   );

   typedef struct {
      logic [PHIT_W-1:0] data;
      logic              last;
      int                due;
   } exp_t;

   exp_t              exp_q[$];
   logic [PHIT_W-1:0] sched [int];
   int                m_used;
   bit                m_perr;
   int                cyc;
   int                n_checks;
   int                n_fail;
   int                n_acc;
   int                obs_hs;
   int                run_len;
   int                max_run;

   function automatic logic [PHIT_W-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // One clock cycle: drive inputs, compare outputs against the model, advance.
   task automatic tick(input bit v, input bit l, input logic [PHIT_W-1:0] pl, input bit rdy);
      bit   exp_rdy;
      bit   tv_exp;
      bit   acc;
      bit   hs;
      exp_t e;
      exp_rdy = (m_used < DEPTH);
      tv_exp  = (exp_q.size() > 0) && (exp_q[0].due <= cyc);

      issue_valid   = v;
      issue_last    = l;
      m_axis_tready = rdy;
      if (sched.exists(cyc)) begin
         dp_data = sched[cyc];
         sched.delete(cyc);
      end else begin
         dp_data = rnd64();
      end

      n_checks++;
      if (issue_ready !== exp_rdy) begin
         n_fail++;
         $display("FAIL issue_ready cyc=%0d got=%b exp=%b", cyc, issue_ready, exp_rdy);
      end
      n_checks++;
      if (used_count !== CNT_W'(m_used)) begin
         n_fail++;
         $display("FAIL used_count cyc=%0d got=%0d exp=%0d", cyc, used_count, m_used);
      end
      n_checks++;
      if (proto_err !== m_perr) begin
         n_fail++;
         $display("FAIL proto_err cyc=%0d got=%b exp=%b", cyc, proto_err, m_perr);
      end
      n_checks++;
      if (m_axis_tvalid !== tv_exp) begin
         n_fail++;
         $display("FAIL tvalid cyc=%0d got=%b exp=%b", cyc, m_axis_tvalid, tv_exp);
      end
      if (tv_exp) begin
         n_checks++;
         if (m_axis_tdata !== exp_q[0].data || m_axis_tlast !== exp_q[0].last) begin
            n_fail++;
            $display("FAIL tdata cyc=%0d got=%h/%b exp=%h/%b", cyc, m_axis_tdata, m_axis_tlast,
                     exp_q[0].data, exp_q[0].last);
         end
      end

      if (m_axis_tvalid === 1'b1 && rdy) obs_hs++;
      if (m_axis_tvalid === 1'b1) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end

      hs  = tv_exp && rdy;
      acc = v && exp_rdy;
      if (v && !exp_rdy) m_perr = 1'b1;
      if (hs) void'(exp_q.pop_front());
      if (acc) begin
         sched[cyc + PIPE_LAT] = pl;
         e.data = pl;
         e.last = l;
         e.due  = cyc + PIPE_LAT + 1;
         exp_q.push_back(e);
         n_acc++;
      end
      m_used = m_used + int'(acc) - int'(hs);

      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst           = 1'b1;
      issue_valid   = 1'b0;
      issue_last    = 1'b0;
      m_axis_tready = 1'b0;
      for (int i = 0; i < n; i++) begin
         dp_data = rnd64();
         #1;
         n_checks++;
         if (issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low cyc=%0d got=%b exp=0", cyc, issue_ready);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      rst = 1'b0;
      exp_q.delete();
      sched.delete();
      m_used  = 0;
      m_perr  = 1'b0;
      run_len = 0;
      #1;
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got tvalid=%b tdata=%h tlast=%b exp 0/0/0",
                  m_axis_tvalid, m_axis_tdata, m_axis_tlast);
      end
      n_checks++;
      if (used_count !== '0 || proto_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_counters got used=%0d perr=%b exp 0/0", used_count, proto_err);
      end
      n_checks++;
      if (issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_high got=%b exp=1", issue_ready);
      end
   endtask

   task automatic drain(input int bound);
      int k = 0;
      while ((exp_q.size() > 0 || m_used != 0) && k < bound) begin
         tick(1'b0, 1'b0, '0, 1'b1);
         k++;
      end
      n_checks++;
      if (used_count !== '0 || m_axis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain got used=%0d tvalid=%b exp 0/0", used_count, m_axis_tvalid);
      end
   endtask

   task automatic test_reset();
      do_reset(3);
   endtask

   task automatic test_single();
      int                c0;
      int                k;
      logic [PHIT_W-1:0] pl;
      pl = 64'hA5A5_0001;
      repeat (3) tick(1'b0, 1'b0, '0, 1'b1);
      c0 = cyc;
      tick(1'b1, 1'b1, pl, 1'b1);
      n_checks++;
      if (used_count !== CNT_W'(1)) begin
         n_fail++;
         $display("FAIL single_used_after_issue got=%0d exp=1", used_count);
      end
      k = 0;
      while (m_axis_tvalid !== 1'b1 && k < 20) begin
         tick(1'b0, 1'b0, '0, 1'b1);
         k++;
      end
      n_checks++;
      if (cyc - c0 != PIPE_LAT + 1) begin
         n_fail++;
         $display("FAIL single_latency got=%0d exp=%0d", cyc - c0, PIPE_LAT + 1);
      end
      n_checks++;
      if (m_axis_tdata !== pl || m_axis_tlast !== 1'b1) begin
         n_fail++;
         $display("FAIL single_data got=%h/%b exp=%h/1", m_axis_tdata, m_axis_tlast, pl);
      end
      tick(1'b0, 1'b0, '0, 1'b1);
      n_checks++;
      if (used_count !== '0) begin
         n_fail++;
         $display("FAIL single_used_after_pop got=%0d exp=0", used_count);
      end
      drain(10);
   endtask

   task automatic test_backpressure();
      int a0;
      int h0;
      a0 = n_acc;
      for (int i = 0; i < 20; i++)
         tick(m_used < DEPTH, 1'($urandom_range(0, 1)), rnd64(), 1'b0);
      n_checks++;
      if (n_acc - a0 != DEPTH) begin
         n_fail++;
         $display("FAIL bp_accepted got=%0d exp=%0d", n_acc - a0, DEPTH);
      end
      n_checks++;
      if (issue_ready !== 1'b0 || used_count !== CNT_W'(DEPTH) || proto_err !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_full got ready=%b used=%0d perr=%b exp 0/%0d/0",
                  issue_ready, used_count, proto_err, DEPTH);
      end
      h0 = obs_hs;
      tick(1'b0, 1'b0, '0, 1'b1);
      n_checks++;
      if (issue_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready_after_pop got=%b exp=1", issue_ready);
      end
      drain(60);
      n_checks++;
      if (obs_hs - h0 != DEPTH) begin
         n_fail++;
         $display("FAIL bp_emerged got=%0d exp=%0d", obs_hs - h0, DEPTH);
      end
   endtask

   task automatic test_stream();
      int h0;
      int drops;
      h0      = obs_hs;
      drops   = 0;
      max_run = 0;
      for (int i = 0; i < 100; i++) begin
         if (issue_ready !== 1'b1) drops++;
         tick(1'b1, i == 99, PHIT_W'(i), 1'b1);
      end
      drain(20);
      n_checks++;
      if (drops != 0) begin
         n_fail++;
         $display("FAIL stream_ready_drops got=%0d exp=0", drops);
      end
      n_checks++;
      if (obs_hs - h0 != 100 || max_run != 100) begin
         n_fail++;
         $display("FAIL stream_continuity got outputs=%0d run=%0d exp 100/100", obs_hs - h0, max_run);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         tick(($urandom_range(0, 3) != 0) && (m_used < DEPTH), 1'($urandom_range(0, 1)),
              rnd64(), $urandom_range(0, 9) < 7);
      drain(60);
   endtask

   task automatic test_proto_err();
      int a0;
      int h0;
      a0 = n_acc;
      for (int i = 0; i < 18; i++)
         tick(m_used < DEPTH, 1'b0, rnd64(), 1'b0);
      tick(1'b1, 1'b1, rnd64(), 1'b0);
      repeat (3) tick(1'b0, 1'b0, '0, 1'b0);
      n_checks++;
      if (proto_err !== 1'b1 || used_count !== CNT_W'(DEPTH) || n_acc - a0 != DEPTH) begin
         n_fail++;
         $display("FAIL proto_state got perr=%b used=%0d acc=%0d exp 1/%0d/%0d",
                  proto_err, used_count, n_acc - a0, DEPTH, DEPTH);
      end
      h0 = obs_hs;
      drain(60);
      n_checks++;
      if (obs_hs - h0 != DEPTH || proto_err !== 1'b1) begin
         n_fail++;
         $display("FAIL proto_emerged got=%0d perr=%b exp %0d/1", obs_hs - h0, proto_err, DEPTH);
      end
   endtask

   task automatic test_mid_reset();
      int h0;
      repeat (5) tick(1'b1, 1'($urandom_range(0, 1)), rnd64(), 1'b0);
      repeat (PIPE_LAT + 1) tick(1'b0, 1'b0, '0, 1'b0);
      repeat (3) tick(1'b1, 1'($urandom_range(0, 1)), rnd64(), 1'b0);
      n_checks++;
      if (used_count !== CNT_W'(8)) begin
         n_fail++;
         $display("FAIL midrst_before got used=%0d exp=8", used_count);
      end
      do_reset(1);
      h0 = obs_hs;
      repeat (2 * PIPE_LAT) tick(1'b0, 1'b0, '0, 1'b1);
      n_checks++;
      if (obs_hs != h0) begin
         n_fail++;
         $display("FAIL midrst_stale got outputs=%0d exp=0", obs_hs - h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_stream();
      test_random();
      test_proto_err();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
